// File: rtl/kme_stream_cfg_core.sv
// Key-management-engine stream core: 2-entry skid FIFO between inbound and outbound
// AXI-Stream, frame-structure checker, beat/frame counters and an APB3 register slave.
module kme_stream_cfg_core #(
  parameter int          APB_AW = 16,
  parameter logic [31:0] REV    = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kme_ib_tvalid,
  output logic              kme_ib_tready,
  input  logic              kme_ib_tlast,
  input  logic              kme_ib_tid,
  input  logic [7:0]        kme_ib_tstrb,
  input  logic [7:0]        kme_ib_tuser,
  input  logic [63:0]       kme_ib_tdata,
  output logic              kme_ob_tvalid,
  output logic              kme_ob_tlast,
  output logic              kme_ob_tid,
  output logic [7:0]        kme_ob_tstrb,
  output logic [7:0]        kme_ob_tuser,
  output logic [63:0]       kme_ob_tdata,
  input  logic              kme_ob_tready,
  input  logic [APB_AW-1:0] apb_paddr,
  input  logic              apb_psel,
  input  logic              apb_penable,
  input  logic              apb_pwrite,
  input  logic [31:0]       apb_pwdata,
  output logic [31:0]       apb_prdata,
  output logic              apb_pready,
  output logic              apb_pslverr,
  output logic              kme_interrupt,
  output logic              kme_idle
);
  typedef struct packed {
    logic        last;
    logic        id;
    logic [7:0]  strb;
    logic [7:0]  user;
    logic [63:0] data;
  } beat_t;

  localparam logic [APB_AW-1:0] A_REV  = APB_AW'('h00);
  localparam logic [APB_AW-1:0] A_SCR  = APB_AW'('h04);
  localparam logic [APB_AW-1:0] A_CTRL = APB_AW'('h08);
  localparam logic [APB_AW-1:0] A_STAT = APB_AW'('h0C);
  localparam logic [APB_AW-1:0] A_IST  = APB_AW'('h10);
  localparam logic [APB_AW-1:0] A_IMSK = APB_AW'('h14);
  localparam logic [APB_AW-1:0] A_BCNT = APB_AW'('h18);
  localparam logic [APB_AW-1:0] A_FCNT = APB_AW'('h1C);

  beat_t       mem [2];
  beat_t       ib_beat, ob_beat;
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        in_frame;
  logic [1:0]  ctrl, int_status, int_mask;
  logic [31:0] scratch, beat_cnt, frame_cnt;
  logic        acc, push, pop, sof, sof_err_set, orphan_set;

  assign ib_beat       = '{last: kme_ib_tlast, id: kme_ib_tid, strb: kme_ib_tstrb,
                           user: kme_ib_tuser, data: kme_ib_tdata};
  assign kme_ib_tready = ctrl[0] & (count != 2'd2);
  assign acc           = kme_ib_tvalid & kme_ib_tready;
  assign push          = acc & ~ctrl[1];
  assign pop           = (count != 2'd0) & kme_ob_tready;
  assign sof           = (kme_ib_tuser == 8'h01);
  assign sof_err_set   = acc & sof & in_frame;
  assign orphan_set    = acc & ~sof & ~in_frame;

  // Head entry is gated so the outbound fields read 0 whenever nothing is queued.
  assign ob_beat       = (count != 2'd0) ? mem[rd_ptr] : '0;
  assign kme_ob_tvalid = (count != 2'd0);
  assign {kme_ob_tlast, kme_ob_tid, kme_ob_tstrb, kme_ob_tuser, kme_ob_tdata} = ob_beat;
  assign kme_idle      = (count == 2'd0) & ~in_frame & ~kme_ib_tvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      in_frame <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ib_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (acc) begin
        if (kme_ib_tlast) in_frame <= 1'b0;
        else if (sof)     in_frame <= 1'b1;
      end
    end
  end

  // APB decode: zero wait states, errors suppress both the write and read data.
  logic        access, hit, ro, wr_ok, rd_ok;
  logic [31:0] rdata;

  always_comb begin
    hit   = 1'b1;
    ro    = 1'b0;
    rdata = '0;
    case (apb_paddr)
      A_REV:  begin rdata = REV; ro = 1'b1; end
      A_SCR:  rdata = scratch;
      A_CTRL: rdata = {30'd0, ctrl};
      A_STAT: begin rdata = {28'd0, count, in_frame, kme_idle}; ro = 1'b1; end
      A_IST:  rdata = {30'd0, int_status};
      A_IMSK: rdata = {30'd0, int_mask};
      A_BCNT: rdata = beat_cnt;
      A_FCNT: rdata = frame_cnt;
      default: hit = 1'b0;
    endcase
  end

  assign access      = apb_psel & apb_penable;
  assign apb_pready  = access;
  assign apb_pslverr = access & (~hit | (apb_pwrite & ro));
  assign wr_ok       = access & apb_pwrite & hit & ~ro;
  assign rd_ok       = access & ~apb_pwrite & hit;
  assign apb_prdata  = rd_ok ? rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch       <= '0;
      ctrl          <= 2'b01;
      int_status    <= '0;
      int_mask      <= '0;
      beat_cnt      <= '0;
      frame_cnt     <= '0;
      kme_interrupt <= 1'b0;
    end else begin
      if (wr_ok && apb_paddr == A_SCR)  scratch  <= apb_pwdata;
      if (wr_ok && apb_paddr == A_CTRL) ctrl     <= apb_pwdata[1:0];
      if (wr_ok && apb_paddr == A_IMSK) int_mask <= apb_pwdata[1:0];
      // Hardware set is OR-ed after the W1C clear so a coincident event is kept.
      int_status <= (int_status & ~((wr_ok && apb_paddr == A_IST) ? apb_pwdata[1:0] : 2'b00))
                  | {orphan_set, sof_err_set};
      if (wr_ok && apb_paddr == A_BCNT)   beat_cnt <= '0;
      else if (acc)                       beat_cnt <= beat_cnt + 32'd1;
      if (wr_ok && apb_paddr == A_FCNT)   frame_cnt <= '0;
      else if (acc && kme_ib_tlast)       frame_cnt <= frame_cnt + 32'd1;
      kme_interrupt <= |(int_status & int_mask);
    end
  end
endmodule

// File: tb/tb_kme_stream_cfg_core.sv
// Randomized bench for kme_stream_cfg_core: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_kme_stream_cfg_core;
  typedef struct packed {
    logic        last;
    logic        id;
    logic [7:0]  strb;
    logic [7:0]  user;
    logic [63:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        ib_tvalid = 0, ib_tlast = 0, ib_tid = 0;
  logic [7:0]  ib_tstrb = 0, ib_tuser = 0;
  logic [63:0] ib_tdata = 0;
  logic        ib_tready;
  logic        ob_tvalid, ob_tlast, ob_tid, ob_tready = 1'b1;
  logic [7:0]  ob_tstrb, ob_tuser;
  logic [63:0] ob_tdata;
  logic [15:0] paddr = 0;
  logic        psel = 0, penable = 0, pwrite = 0;
  logic [31:0] pwdata = 0, prdata;
  logic        pready, pslverr, irq, idle;

  kme_stream_cfg_core #(.APB_AW(16), .REV(32'h0001_0000)) dut (
    .clk(clk), .rst(rst),
    .kme_ib_tvalid(ib_tvalid), .kme_ib_tready(ib_tready), .kme_ib_tlast(ib_tlast),
    .kme_ib_tid(ib_tid), .kme_ib_tstrb(ib_tstrb), .kme_ib_tuser(ib_tuser), .kme_ib_tdata(ib_tdata),
    .kme_ob_tvalid(ob_tvalid), .kme_ob_tlast(ob_tlast), .kme_ob_tid(ob_tid),
    .kme_ob_tstrb(ob_tstrb), .kme_ob_tuser(ob_tuser), .kme_ob_tdata(ob_tdata),
    .kme_ob_tready(ob_tready),
    .apb_paddr(paddr), .apb_psel(psel), .apb_penable(penable), .apb_pwrite(pwrite),
    .apb_pwdata(pwdata), .apb_prdata(prdata), .apb_pready(pready), .apb_pslverr(pslverr),
    .kme_interrupt(irq), .kme_idle(idle)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          mv = 0;
  beat_t       q[$];
  bit          m_in_frame, m_irq;
  logic [1:0]  m_ctrl, m_ist, m_mask;
  logic [31:0] m_scr, m_bc, m_fc;
  logic [63:0] obs[$];

  function automatic logic [31:0] mreg(input logic [15:0] a, output bit hit, output bit ro);
    bit m_idle;
    m_idle = (q.size() == 0) && !m_in_frame && !ib_tvalid;
    hit = 1; ro = 0;
    case (a)
      16'h00: begin ro = 1; return 32'h0001_0000; end
      16'h04: return m_scr;
      16'h08: return {30'd0, m_ctrl};
      16'h0C: begin ro = 1; return (32'(q.size()) << 2) | (32'(m_in_frame) << 1) | 32'(m_idle); end
      16'h10: return {30'd0, m_ist};
      16'h14: return {30'd0, m_mask};
      16'h18: return m_bc;
      16'h1C: return m_fc;
      default: begin hit = 0; return 32'd0; end
    endcase
  endfunction

  always begin
    @(negedge clk); #4;
    if (rst) begin
      q.delete(); m_in_frame = 0; m_irq = 0; m_ctrl = 2'b01; m_ist = 0; m_mask = 0;
      m_scr = 0; m_bc = 0; m_fc = 0; mv = 1;
    end else if (mv) begin
      int n; bit exp_rdy, access, hit, ro, err, acc, sof, wr, new_irq;
      logic [31:0] rv;
      beat_t in_b;
      n = q.size();
      exp_rdy = m_ctrl[0] && n < 2;
      chk("ib_tready", ib_tready, exp_rdy);
      chk("ob_tvalid", ob_tvalid, n > 0);
      chk("ob_beat", {ob_tlast, ob_tid, ob_tstrb, ob_tuser, ob_tdata}, n > 0 ? q[0] : beat_t'(0));
      chk("idle", idle, n == 0 && !m_in_frame && !ib_tvalid);
      chk("interrupt", irq, m_irq);
      access = psel && penable;
      rv = mreg(paddr, hit, ro);
      err = access && (!hit || (pwrite && ro));
      chk("pready", pready, access);
      chk("pslverr", pslverr, err);
      chk("prdata", prdata, (access && !pwrite && hit) ? rv : 32'd0);
      // advance model by one clock
      if (n > 0 && ob_tready) begin obs.push_back(q[0].data); void'(q.pop_front()); end
      acc = ib_tvalid && exp_rdy;
      sof = ib_tuser == 8'h01;
      in_b = '{ib_tlast, ib_tid, ib_tstrb, ib_tuser, ib_tdata};
      new_irq = |(m_ist & m_mask);
      wr = access && pwrite && hit && !ro;
      m_ist = m_ist & ~((wr && paddr == 16'h10) ? pwdata[1:0] : 2'b00);
      if (acc) begin
        if (sof && m_in_frame) m_ist[0] = 1;
        if (!sof && !m_in_frame) m_ist[1] = 1;
        if (!m_ctrl[1]) q.push_back(in_b);
        if (ib_tlast) m_in_frame = 0; else if (sof) m_in_frame = 1;
      end
      m_bc = (wr && paddr == 16'h18) ? 32'd0 : m_bc + 32'(acc);
      m_fc = (wr && paddr == 16'h1C) ? 32'd0 : m_fc + 32'(acc && ib_tlast);
      if (wr && paddr == 16'h04) m_scr = pwdata;
      if (wr && paddr == 16'h08) m_ctrl = pwdata[1:0];
      if (wr && paddr == 16'h14) m_mask = pwdata[1:0];
      m_irq = new_irq;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apb_wr(input logic [15:0] a, input logic [31:0] d);
    paddr = a; pwrite = 1; pwdata = d; psel = 1; penable = 0;
    @(negedge clk); penable = 1;
    @(negedge clk); psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_rd(input logic [15:0] a, output logic [31:0] d, output logic e);
    paddr = a; pwrite = 0; psel = 1; penable = 0;
    @(negedge clk); penable = 1;
    #4; d = prdata; e = pslverr;
    @(negedge clk); psel = 0; penable = 0;
  endtask

  task automatic send_beat(input logic [7:0] user, input logic last, input logic [63:0] data);
    bit a;
    ib_tuser = user; ib_tlast = last; ib_tdata = data; ib_tstrb = 8'hFF; ib_tid = 0; ib_tvalid = 1;
    a = 0;
    for (int k = 0; k < 200 && !a; k++) begin
      #4; a = ib_tready;
      @(negedge clk);
    end
    if (!a) begin errors++; checks++; $display("FAIL send_beat timeout data %h", data); end
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] bc_before;

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    #4;
    chk("rst_tready", ib_tready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_ob_tvalid", ob_tvalid, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk);

    apb_rd(16'h00, rd, er); chk("rev", rd, 32'h0001_0000); chk("rev_err", er, 0);
    apb_wr(16'h04, 32'hDEAD_BEEF);
    apb_rd(16'h04, rd, er); chk("scratch", rd, 32'hDEAD_BEEF);
    apb_rd(16'h40, rd, er); chk("unmapped_err", er, 1); chk("unmapped_data", rd, 0);
    apb_wr(16'h00, 32'h5);

    // 3-beat frame
    ob_tready = 1;
    send_beat(8'h01, 0, 64'h11); send_beat(8'h00, 0, 64'h22); send_beat(8'h02, 1, 64'h33);
    ib_tvalid = 0; ib_tlast = 0;
    repeat (2) @(negedge clk);
    #4; chk("frame_idle", idle, 1);
    @(negedge clk);
    apb_rd(16'h18, rd, er); chk("beat_cnt", rd, 3);
    apb_rd(16'h1C, rd, er); chk("frame_cnt", rd, 1);

    // backpressure: 5 beats with outbound stalled
    obs.delete();
    ob_tready = 0;
    send_beat(8'h01, 0, 64'hA0); send_beat(8'h00, 0, 64'hA1);
    ib_tuser = 8'h00; ib_tdata = 64'hA2;
    repeat (3) begin
      #4; chk("full_tready", ib_tready, 0); chk("held_data", ob_tdata, 64'hA0);
      @(negedge clk);
    end
    ob_tready = 1;
    send_beat(8'h00, 0, 64'hA2); send_beat(8'h00, 0, 64'hA3); send_beat(8'h02, 1, 64'hA4);
    ib_tvalid = 0; ib_tlast = 0;
    repeat (4) @(negedge clk);
    chk("drain_n", obs.size(), 5);
    for (int i = 0; i < 5 && i < obs.size(); i++) chk("drain_order", obs[i], 64'hA0 + 64'(i));

    // SOF error interrupt
    apb_wr(16'h14, 32'h1);
    send_beat(8'h01, 0, 64'h1); send_beat(8'h01, 0, 64'h2);
    ib_tvalid = 0;
    apb_rd(16'h10, rd, er); chk("int_status", rd, 1);
    #4; chk("irq_high", irq, 1); @(negedge clk);
    apb_wr(16'h10, 32'h1);
    @(negedge clk);
    #4; chk("irq_low", irq, 0); @(negedge clk);
    apb_rd(16'h10, rd, er); chk("int_cleared", rd, 0);
    send_beat(8'h00, 1, 64'h3); ib_tvalid = 0; ib_tlast = 0;

    // disabled stream
    apb_rd(16'h18, bc_before, er);
    apb_wr(16'h08, 32'h0);
    ib_tvalid = 1;
    repeat (5) begin #4; chk("dis_tready", ib_tready, 0); @(negedge clk); end
    ib_tvalid = 0;
    apb_rd(16'h18, rd, er); chk("dis_cnt", rd, bc_before);
    apb_wr(16'h08, 32'h1);

    // randomized traffic with APB activity and occasional resets
    begin
      int ph = 0;
      logic [15:0] addrs [10] = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h18, 16'h1C, 16'h40, 16'h02};
      logic [7:0]  users [4]  = '{8'h01, 8'h00, 8'h02, 8'h5A};
      for (int c = 0; c < 4000; c++) begin
        ib_tvalid = ($urandom % 3) != 0;
        ib_tuser  = users[$urandom % 4];
        ib_tlast  = ($urandom % 4) == 0;
        ib_tdata  = {$urandom, $urandom};
        ib_tstrb  = 8'($urandom);
        ib_tid    = 1'($urandom);
        ob_tready = ($urandom % 4) != 0;
        case (ph)
          0: if ($urandom % 5 == 0) begin
               paddr = addrs[$urandom % 10]; pwrite = 1'($urandom); pwdata = $urandom;
               if (paddr == 16'h08) pwdata[0] = ($urandom % 4) != 0;
               psel = 1; penable = 0; ph = 1;
             end
          1: begin penable = 1; ph = 2; end
          default: begin psel = 0; penable = 0; ph = 0; end
        endcase
        rst = ($urandom % 500) == 0;
        if (rst) begin ph = 0; end
        @(negedge clk);
      end
      rst = 0; psel = 0; penable = 0; ib_tvalid = 0;
      repeat (4) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kme_stream_cfg_core.md
Name: kme_stream_cfg_core

Overview:
- Reduced key-management-engine datapath core. Forwards an inbound 64-bit AXI-Stream, unchanged, to one outbound AXI-Stream through a 2-entry skid buffer.
- Checks frame structure on the inbound stream and counts beats and frames.
- Exposes control, status and interrupt through an APB3 register slave.
- Sits between the host-facing stream fabric and downstream crypto engines.

Parameters:
- APB_AW, 16, APB address width (byte address).
- REV, 32'h0001_0000, value returned by the REVISION register.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- kme_ib_tvalid  in  1  inbound beat valid.
- kme_ib_tready  out  1  inbound ready.
- kme_ib_tlast  in  1  last beat of frame.
- kme_ib_tid  in  1  stream id.
- kme_ib_tstrb  in  8  byte strobes.
- kme_ib_tuser  in  8  beat tag: 0x01 = start-of-frame (SOF), 0x02 = end-of-TLV, other = data.
- kme_ib_tdata  in  64  payload.
- kme_ob_tvalid, kme_ob_tlast, kme_ob_tid, kme_ob_tstrb, kme_ob_tuser, kme_ob_tdata  out  1/1/1/8/8/64  outbound copy of the inbound beat.
- kme_ob_tready  in  1  outbound ready.
- apb_paddr  in  APB_AW  byte address.
- apb_psel, apb_penable, apb_pwrite  in  1  APB control.
- apb_pwdata  in  32  write data.
- apb_prdata  out  32  read data.
- apb_pready  out  1  transfer ready.
- apb_pslverr  out  1  slave error.
- kme_interrupt  out  1  level interrupt.
- kme_idle  out  1  idle indicator.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Buffer empties; in_frame clears; all counters, SCRATCH, INT_STATUS and INT_MASK clear; CTRL = 0x1.
  - All outputs 0 except kme_idle = 1 and kme_ib_tready = 1 on the cycle after reset.
  - Reset mid-frame or mid-APB-access discards all state; no partial beat is emitted.
- Stream path:
  - Inbound beat accepted when tvalid & tready.
  - 2-entry FIFO (skid); tready = CTRL.EN & (FIFO not full).
  - Latency: a beat accepted at edge N is presented on ob at edge N+1 if the FIFO was empty.
  - Sustained throughput is 1 beat/cycle when ob_tready=1.
  - Beat fields pass through bit-exact.
  - Outbound holds all ob signals stable while tvalid=1 & tready=0.
  - With FIFO full, tready is deasserted; a simultaneous pop-and-push when holding 1 entry keeps the count at 1.
  - CTRL.DROP=1: accepted beats are counted and checked but not pushed; ob_tvalid stays 0 for them.
- Frame checker (on accepted beats):
  - SOF while in_frame: set INT_STATUS.SOF_ERR; stay in frame.
  - Non-SOF while !in_frame: set INT_STATUS.ORPHAN.
  - SOF sets in_frame.
  - tlast clears in_frame and increments FRAME_CNT. SOF with tlast in the same beat is a one-beat frame.
  - Beats are forwarded regardless of errors.
- Counters: 32-bit, wrap from 0xFFFF_FFFF to 0. Any APB write to a counter clears it; a clear has priority over a simultaneous increment.
- kme_interrupt = |(INT_STATUS & INT_MASK), registered (1-cycle delay).
- kme_idle = FIFO empty & !in_frame & !kme_ib_tvalid.
- APB:
  - Zero wait states: pready = psel & penable.
  - Writes take effect at the access-phase edge.
  - prdata is valid during the access phase and is 0 otherwise.
  - Unmapped address or write to a RO register: pslverr = 1 in the access phase; no state change; prdata = 0.
  - A hardware set in the same cycle as a W1C clear wins (the bit stays 1).
- Register map (byte offsets):
  - 0x00 REVISION  RO  = REV.
  - 0x04 SCRATCH  RW  32-bit.
  - 0x08 CTRL  RW  bit0 EN, bit1 DROP.
  - 0x0C STATUS  RO  bit0 idle, bit1 in_frame, bits3:2 FIFO count.
  - 0x10 INT_STATUS  W1C  bit0 SOF_ERR, bit1 ORPHAN.
  - 0x14 INT_MASK  RW  bits1:0.
  - 0x18 IB_BEAT_CNT  RW-clear.
  - 0x1C FRAME_CNT  RW-clear.

Test Plan:
- Reset then APB read 0x00 -> 0x0001_0000, pslverr=0.
- APB write 0x04=0xDEAD_BEEF, then read -> 0xDEAD_BEEF.
- APB read 0x40 -> pslverr=1, prdata=0.
- 3-beat frame (tuser 0x01, 0x00, 0x02+tlast, tdata 0x11/0x22/0x33), ob_tready=1:
  - ob shows the same beats one cycle later.
  - IB_BEAT_CNT=3, FRAME_CNT=1, kme_idle returns to 1.
- ob_tready=0 while streaming 5 beats:
  - tready drops after 2 accepts; ob data is held stable.
  - Raising ob_tready drains all 5 beats in order.
- Two SOF beats with no tlast, INT_MASK=0x1:
  - INT_STATUS=0x1; kme_interrupt rises next cycle.
  - Write 0x10=0x1 -> INT_STATUS=0 and kme_interrupt falls.
- CTRL=0x0 -> kme_ib_tready=0; no beats accepted; counters unchanged.
